mem_access_sequencer: RTL
=========================

Name: mem_access_sequencer

Overview:
- Multi-cycle sequencer for data-memory loads and stores.
- Sits between the decode/control stage (Mem_read, Mem_write, funct3) and a variable-latency data memory with a req/ack handshake.
- Stalls the pipeline while an access is in flight, and generates byte enables, lane steering and load sign/zero extension.
- Reports misaligned, illegal-funct3 and timeout faults.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; fixed at 32 because lane logic assumes 4 bytes.
- TIMEOUT, 16, maximum cycles mem_req stays high without mem_ack; must be >= 2.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  access request from pipeline; sampled only in IDLE
- mem_read  in  1  load request (control Mem_read)
- mem_write  in  1  store request (control Mem_write)
- funct3  in  3  instruction bits 14:12
- addr  in  ADDR_W  effective address from ALU
- wdata  in  DATA_W  store data (rs2)
- stall  out  1  freeze PC/pipeline
- done  out  1  one-cycle completion pulse
- fault  out  2  fault code, valid with done
- rdata_out  out  DATA_W  extended load result, valid with done
- mem_req  out  1  memory request
- mem_we  out  1  1 = store
- mem_addr  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
- mem_wdata  out  DATA_W  lane-replicated store data
- mem_be  out  4  byte enables
- mem_ack  in  1  memory completion; read data valid in the same cycle
- mem_rdata  in  DATA_W  memory read word

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous, active-high, port rst.
- Reset values:
  - State = IDLE.
  - All outputs 0, including rdata_out, fault, mem_be and the timer.
  - Reset mid-access drops mem_req immediately, with no completion pulse.
- Valid start: start=1 in IDLE with exactly one of mem_read/mem_write set. Both or neither set: the request is ignored and the sequencer stays in IDLE.
- IDLE, on a valid start:
  - Latch op, funct3, addr[1:0], mem_addr, mem_be and mem_wdata into registers.
  - Check illegal funct3:
    - Loads: only 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU are legal.
    - Stores: only 000 SB, 001 SH, 010 SW are legal.
    - Illegal -> FAULT, code 11.
  - Check alignment:
    - Halfword access with addr[0]=1 is misaligned.
    - Word access with addr[1:0]!=0 is misaligned.
    - Misaligned -> FAULT, code 01.
  - Priority: illegal over misaligned. No mem_req is issued on either fault.
  - Otherwise -> ACCESS.
- ACCESS:
  - mem_req=1 from the first ACCESS cycle.
  - mem_we, mem_addr, mem_be and mem_wdata are held stable until exit.
  - Timer is cleared on entry and increments each cycle without ack.
  - mem_ack=1 -> capture the extended load data into rdata_out (stores leave rdata_out unchanged), then -> DONE.
  - No ack while timer == TIMEOUT-1 -> FAULT, code 10. This gives mem_req high for exactly TIMEOUT cycles.
  - Ack in the timeout cycle: ack wins.
  - The cycle after ack, mem_req=0.
- DONE: done=1 and fault=00 for one cycle, then -> IDLE.
- FAULT: done=1 with the fault code for one cycle; rdata_out=0; then -> IDLE.
- stall = (IDLE & valid start) | ACCESS. It is combinational and is 0 in DONE/FAULT, so the pipeline advances on done.
- start in ACCESS/DONE/FAULT is ignored. mem_ack outside ACCESS is ignored.
- Byte enables:
  - Byte access: 4'b0001 << addr[1:0].
  - Half access: addr[1] ? 1100 : 0011.
  - Word access: 1111.
  - Applied to loads as well as stores.
- Store data:
  - SB replicates wdata[7:0] into all 4 lanes.
  - SH replicates wdata[15:0] into both halves.
  - SW passes wdata unchanged.
- Load data:
  - Select the byte or half lane by the latched addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
- Latency: a load with ack on the Nth ACCESS cycle gives done N+1 cycles after the start cycle.

Test Plan:
- LW addr=0x100, mem_rdata=0xDEADBEEF, ack on 3rd ACCESS cycle -> mem_req high 3 cycles, mem_be=1111; done 4 cycles after start with rdata_out=0xDEADBEEF, fault=00; stall high until done.
- LB addr=0x103, mem_rdata=0x80112233 -> mem_be=1000, rdata_out=0xFFFFFF80. Repeat as LBU -> rdata_out=0x00000080.
- SH addr=0x202, wdata=0x0000ABCD, immediate ack -> mem_we=1, mem_be=1100, mem_wdata=0xABCDABCD; done pulse, fault=00.
- LW addr=0x102 -> no mem_req; done next cycle with fault=01. Store with funct3=011 -> fault=11. Both mem_read and mem_write set -> no action, stall=0.
- TIMEOUT=16, mem_ack tied low -> mem_req high exactly 16 cycles, then done with fault=10. Variant with ack on the 16th cycle -> fault=00.
- Assert rst on the 2nd ACCESS cycle -> mem_req, stall and done go 0 immediately. A new LW after release completes normally.

Source files
------------

// File: rtl/mem_access_sequencer.sv
// Multi-cycle load/store sequencer between decode and a req/ack data memory.
// Latches one access, checks funct3 legality and alignment, drives the memory
// handshake with a timeout, and returns a lane-steered, extended load result.
module mem_access_sequencer #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              stall,
  output logic              done,
  output logic [1:0]        fault,
  output logic [DATA_W-1:0] rdata_out,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;
  localparam logic [1:0] FAULT  = 2'd3;

  localparam logic [1:0] F_NONE    = 2'b00;
  localparam logic [1:0] F_MISALGN = 2'b01;
  localparam logic [1:0] F_TIMEOUT = 2'b10;
  localparam logic [1:0] F_ILLEGAL = 2'b11;

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  logic [1:0]        state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        off_q, off_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        fault_q, fault_d;

  logic              valid_start, illegal, misalign;
  logic [3:0]        be_new;
  logic [DATA_W-1:0] wd_new, ld_ext;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;

  assign valid_start = start & (mem_read ^ mem_write);

  // Request decode: legality, alignment, byte enables and store lane replication
  always_comb begin
    if (mem_read)
      illegal = !(funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    else
      illegal = funct3[2] | (funct3[1:0] == 2'b11);
    misalign = ((funct3[1:0] == 2'b01) && addr[0]) ||
               ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    case (funct3[1:0])
      2'b00:   begin be_new = 4'b0001 << addr[1:0];           wd_new = {4{wdata[7:0]}};  end
      2'b01:   begin be_new = addr[1] ? 4'b1100 : 4'b0011;    wd_new = {2{wdata[15:0]}}; end
      default: begin be_new = 4'b1111;                        wd_new = wdata;            end
    endcase
  end

  // Load lane selection and sign/zero extension from the latched offset and funct3
  always_comb begin
    ld_byte = mem_rdata[{off_q, 3'b000} +: 8];
    ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'd0, ld_byte};
      3'b101:  ld_ext = {16'd0, ld_half};
      default: ld_ext = mem_rdata;
    endcase
  end

  // Sequencer next-state: IDLE -> ACCESS/FAULT, ACCESS -> DONE/FAULT, then back to IDLE
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    off_d   = off_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wd_d    = wd_q;
    timer_d = timer_q;
    rdata_d = rdata_q;
    fault_d = fault_q;
    case (state_q)
      IDLE: begin
        if (valid_start) begin
          we_d    = mem_write;
          f3_d    = funct3;
          off_d   = addr[1:0];
          addr_d  = {addr[ADDR_W-1:2], 2'b00};
          be_d    = be_new;
          wd_d    = wd_new;
          timer_d = '0;
          // Illegal funct3 outranks misalignment; neither issues a request.
          if (illegal) begin
            state_d = FAULT;
            fault_d = F_ILLEGAL;
            rdata_d = '0;
          end else if (misalign) begin
            state_d = FAULT;
            fault_d = F_MISALGN;
            rdata_d = '0;
          end else begin
            state_d = ACCESS;
            fault_d = F_NONE;
          end
        end
      end
      ACCESS: begin
        // An ack in the last allowed cycle still completes the access.
        if (mem_ack) begin
          state_d = DONE;
          fault_d = F_NONE;
          if (!we_q) rdata_d = ld_ext;
        end else if (timer_q == T_LAST) begin
          state_d = FAULT;
          fault_d = F_TIMEOUT;
          rdata_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      off_q   <= '0;
      addr_q  <= '0;
      be_q    <= '0;
      wd_q    <= '0;
      timer_q <= '0;
      rdata_q <= '0;
      fault_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wd_q    <= wd_d;
      timer_q <= timer_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
    end
  end

  // Stall covers the accepting IDLE cycle and all of ACCESS so the pipeline moves on done.
  assign stall     = (state_q == IDLE && valid_start) || (state_q == ACCESS);
  assign mem_req   = (state_q == ACCESS);
  assign done      = (state_q == DONE) || (state_q == FAULT);
  assign fault     = (state_q == FAULT) ? fault_q : F_NONE;
  assign rdata_out = rdata_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_be    = be_q;
  assign mem_wdata = wd_q;

endmodule
